// File: rtl/case_1_mul_share_arb.sv
// Round-robin arbiter sharing one signed multiplier among N_REQ requesters.
// The result lands in a one-entry output register with valid/ready handshake.
module case_1_mul_share_arb #(
  parameter int N_REQ      = 4,
  parameter int DIN0_WIDTH = 14,
  parameter int DIN1_WIDTH = 13,
  parameter int DOUT_WIDTH = 27
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*DIN0_WIDTH-1:0]   req_a,
  input  logic [N_REQ*DIN1_WIDTH-1:0]   req_b,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [DOUT_WIDTH-1:0]         res_data,
  output logic [$clog2(N_REQ)-1:0]      res_id,
  output logic [15:0]                   op_count
);

  localparam int IDW = $clog2(N_REQ);

  if (N_REQ != 2 && N_REQ != 4) begin : g_bad_nreq
    $error("N_REQ must be 2 or 4");
  end
  if (DOUT_WIDTH != DIN0_WIDTH + DIN1_WIDTH) begin : g_bad_dout
    $error("DOUT_WIDTH must equal DIN0_WIDTH + DIN1_WIDTH");
  end

  logic                               r_res_valid;
  logic [DOUT_WIDTH-1:0]              r_res_data;
  logic [IDW-1:0]                     r_res_id;
  logic [IDW-1:0]                     r_rr_ptr;
  logic [15:0]                        r_op_count;

  logic [N_REQ-1:0][DIN0_WIDTH-1:0]   w_a_arr;
  logic [N_REQ-1:0][DIN1_WIDTH-1:0]   w_b_arr;
  logic                               w_free;
  logic                               w_any;
  logic                               w_xfer;
  logic [IDW-1:0]                     w_gnt_idx;
  logic signed [DIN0_WIDTH-1:0]       w_a;
  logic signed [DIN1_WIDTH-1:0]       w_b;
  logic signed [DOUT_WIDTH-1:0]       w_a_ext;
  logic signed [DOUT_WIDTH-1:0]       w_b_ext;
  logic signed [DOUT_WIDTH-1:0]       w_prod;

  assign w_a_arr = req_a;
  assign w_b_arr = req_b;

  assign w_free = !r_res_valid || res_ready;

  // N_REQ is a power of two, so IDW-bit addition wraps modulo N_REQ.
  always_comb begin
    logic [IDW-1:0] v_idx;
    w_any     = 1'b0;
    w_gnt_idx = '0;
    v_idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      v_idx = r_rr_ptr + IDW'(k);
      if (!w_any && req_valid[v_idx]) begin
        w_any     = 1'b1;
        w_gnt_idx = v_idx;
      end
    end
  end

  assign w_xfer    = w_free && w_any && !ap_rst;
  assign req_ready = w_xfer ? (N_REQ'(1) << w_gnt_idx) : '0;

  // Single shared multiplier; operands sign-extended to the full product width.
  assign w_a     = w_a_arr[w_gnt_idx];
  assign w_b     = w_b_arr[w_gnt_idx];
  assign w_a_ext = {{(DOUT_WIDTH-DIN0_WIDTH){w_a[DIN0_WIDTH-1]}}, w_a};
  assign w_b_ext = {{(DOUT_WIDTH-DIN1_WIDTH){w_b[DIN1_WIDTH-1]}}, w_b};
  assign w_prod  = w_a_ext * w_b_ext;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
      r_rr_ptr    <= '0;
      r_op_count  <= '0;
    end else begin
      if (w_xfer) begin
        r_res_valid <= 1'b1;
        r_res_data  <= w_prod;
        r_res_id    <= w_gnt_idx;
        r_rr_ptr    <= w_gnt_idx + IDW'(1);
      end else if (res_ready) begin
        r_res_valid <= 1'b0;
      end
      if (r_res_valid && res_ready) begin
        r_op_count <= r_op_count + 16'd1;
      end
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_case_1_mul_share_arb.sv
// Scoreboard bench: driver predicts grants/products from the arbitration rules,
// a separate monitor compares every presented result against the queue.
module tb_case_1_mul_share_arb;

  localparam int N  = 4;
  localparam int AW = 14;
  localparam int BW = 13;
  localparam int DW = 27;

  logic              ap_clk;
  logic              ap_rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   req_a;
  logic [N*BW-1:0]   req_b;
  logic              res_valid;
  logic              res_ready;
  logic [DW-1:0]     res_data;
  logic [1:0]        res_id;
  logic [15:0]       op_count;

  case_1_mul_share_arb #(.N_REQ(N), .DIN0_WIDTH(AW), .DIN1_WIDTH(BW), .DOUT_WIDTH(DW)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .op_count(op_count)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct { longint data; int id; } exp_t;
  exp_t q[$];

  int n_pass = 0;
  int n_tot  = 0;
  int m_ptr  = 0;
  bit m_full = 0;
  int m_deliv = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  function automatic longint sxa(input logic [N*AW-1:0] v, input int i);
    logic signed [AW-1:0] t;
    t = v[i*AW +: AW];
    return longint'(t);
  endfunction

  function automatic longint sxb(input logic [N*BW-1:0] v, input int i);
    logic signed [BW-1:0] t;
    t = v[i*BW +: BW];
    return longint'(t);
  endfunction

  function automatic logic [N*AW-1:0] pa(input int i, input int val);
    logic [N*AW-1:0] t;
    t = '0;
    t[i*AW +: AW] = AW'(val);
    return t;
  endfunction

  function automatic logic [N*BW-1:0] pb(input int i, input int val);
    logic [N*BW-1:0] t;
    t = '0;
    t[i*BW +: BW] = BW'(val);
    return t;
  endfunction

  function automatic logic [N*AW-1:0] ra();
    return {24'($urandom), $urandom()};
  endfunction

  function automatic logic [N*BW-1:0] rb();
    return {20'($urandom), $urandom()};
  endfunction

  // One cycle: drive on the falling edge, predict the grant from the round-robin
  // rule and the output-register occupancy, queue the expected product.
  task automatic cycle(input logic [N-1:0] v, input logic [N*AW-1:0] a,
                       input logic [N*BW-1:0] b, input logic rdy, output int g);
    logic [N-1:0] e;
    @(negedge ap_clk);
    req_valid = v; req_a = a; req_b = b; res_ready = rdy;
    #1;
    chk("res_valid", longint'(res_valid), longint'(m_full));
    g = -1;
    if (!m_full || rdy)
      for (int k = 0; k < N; k++)
        if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    e = (g >= 0) ? N'(1 << g) : '0;
    chk("req_ready", longint'(req_ready), longint'(e));
    if (g >= 0) begin
      q.push_back('{sxa(a, g) * sxb(b, g), g});
      m_ptr  = (g + 1) % N;
      m_full = 1;
    end else if (rdy) begin
      m_full = 0;
    end
  endtask

  task automatic idle(input logic rdy);
    int g;
    cycle('0, '0, '0, rdy, g);
  endtask

  // Monitor: compares the held result with the queue head and tracks deliveries.
  initial begin
    forever begin
      @(negedge ap_clk or posedge ap_rst);
      if (ap_rst) begin
        q.delete();
        m_deliv = 0;
      end else begin
        #2;
        if (!ap_rst) begin
          chk("op_count", longint'(op_count), longint'(m_deliv & 16'hFFFF));
          if (res_valid) begin
            if (q.size() == 0) begin
              chk("res_unexpected", 1, 0);
            end else begin
              chk("res_data", longint'($signed(res_data)), q[0].data);
              chk("res_id", longint'(res_id), longint'(q[0].id));
              if (res_ready) begin
                void'(q.pop_front());
                m_deliv++;
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_tot);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g;
    ap_rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b0;
    repeat (3) @(negedge ap_clk);
    req_valid = 4'b1111; res_ready = 1'b1;
    #1;
    chk("rst_req_ready", longint'(req_ready), 0);
    chk("rst_res_valid", longint'(res_valid), 0);
    chk("rst_res_data", longint'(res_data), 0);
    chk("rst_res_id", longint'(res_id), 0);
    chk("rst_op_count", longint'(op_count), 0);
    #2 ap_rst = 1'b0;
    req_valid = '0;

    // Single op
    cycle(4'b0001, pa(0, -8192), pb(0, 4095), 1'b1, g);
    chk("single_gnt", g, 0);
    idle(1'b1);
    chk("single_data", longint'($signed(res_data)), -33546240);
    chk("single_id", longint'(res_id), 0);
    idle(1'b1);
    chk("single_cnt", longint'(op_count), 1);

    // Bring pointer back to 0, then full-load round robin
    cycle(4'b1000, ra(), rb(), 1'b1, g);
    for (int i = 0; i < 8; i++) begin
      cycle(4'b1111, ra(), rb(), 1'b1, g);
      chk("rr_order", g, i % N);
    end
    idle(1'b1);
    idle(1'b1);

    // Backpressure
    cycle(4'b0001, ra(), rb(), 1'b1, g);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0110, ra(), rb(), 1'b0, g);
      chk("bp_no_gnt", g, -1);
    end
    cycle(4'b0110, ra(), rb(), 1'b1, g);
    chk("bp_release_gnt", g, 1);
    idle(1'b1);
    idle(1'b1);

    // Extreme operands
    cycle(4'b0001, pa(0, -8192), pb(0, -4096), 1'b1, g);
    cycle(4'b0001, pa(0, 8191), pb(0, 4095), 1'b1, g);
    chk("ext_negneg", longint'($signed(res_data)), 33554432);
    idle(1'b1);
    chk("ext_pospos", longint'($signed(res_data)), 33542145);
    idle(1'b1);

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++)
      cycle(N'($urandom), ra(), rb(), ($urandom % 4) != 0, g);
    repeat (2) idle(1'b1);

    // Reset while a result is held
    cycle(4'b0001, ra(), rb(), 1'b0, g);
    idle(1'b0);
    #2 ap_rst = 1'b1;
    #1;
    chk("midrst_res_valid", longint'(res_valid), 0);
    chk("midrst_op_count", longint'(op_count), 0);
    ap_rst = 1'b0;
    m_full = 0; m_ptr = 0;
    cycle(4'b1000, pa(3, 100), pb(3, -7), 1'b1, g);
    chk("postrst_gnt", g, 3);
    idle(1'b1);
    chk("postrst_id", longint'(res_id), 3);
    chk("postrst_data", longint'($signed(res_data)), -700);

    // op_count wrap: one delivery so far, bring it to 0xFFFF then one more
    for (int i = 0; i < 65535; i++)
      cycle(4'b0001, ra(), rb(), 1'b1, g);
    idle(1'b0);
    chk("wrap_ffff", longint'(op_count), 65535);
    idle(1'b1);
    idle(1'b1);
    chk("wrap_zero", longint'(op_count), 0);

    @(negedge ap_clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
